// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Single outstanding request: req is held with stable attributes until ack.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the RV32I pipeline: decodes size/signedness,
// checks alignment, steers byte lanes, runs a single-outstanding memory
// request with a watchdog, and returns extended load data to the register file.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_op_valid,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [4:0]            rd_in,
  output logic                  lsu_ready,
  output logic                  lsu_busy,
  load_store_unit_if.master     mem,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  lsu_err,
  output logic [1:0]            err_cause
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t     state_reg;
  logic [2:0] funct3_reg;
  logic [4:0] rd_reg;
  logic [1:0] off_reg;
  logic       store_reg;
  logic [7:0] wd_count_reg;

  logic                  is_load, is_store, legal, misaligned;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  // Decode the incoming operation: legality, alignment and store lane steering.
  always_comb begin
    is_load  = (opcode == OP_LOAD);
    is_store = (opcode == OP_STORE);
    if (is_store)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    // funct3[1:0] encodes size for every legal code: 00 byte, 01 half, 10 word.
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {addr[1], 1'b0};
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  // Select and extend the loaded byte/half using the latched offset and funct3.
  always_comb begin
    case (off_reg)
      2'd0:    ld_byte = mem.dmem_rdata[7:0];
      2'd1:    ld_byte = mem.dmem_rdata[15:8];
      2'd2:    ld_byte = mem.dmem_rdata[23:16];
      default: ld_byte = mem.dmem_rdata[31:24];
    endcase
    ld_half = off_reg[1] ? mem.dmem_rdata[31:16] : mem.dmem_rdata[15:0];
    case (funct3_reg)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem.dmem_rdata;
    endcase
  end

  // Control FSM with registered bus, writeback and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      lsu_ready      <= 1'b1;
      lsu_busy       <= 1'b0;
      mem.dmem_req   <= 1'b0;
      mem.dmem_we    <= 1'b0;
      mem.dmem_addr  <= '0;
      mem.dmem_be    <= 4'b0000;
      mem.dmem_wdata <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= 5'd0;
      wb_data        <= '0;
      lsu_err        <= 1'b0;
      err_cause      <= 2'b00;
      funct3_reg     <= 3'd0;
      rd_reg         <= 5'd0;
      off_reg        <= 2'd0;
      store_reg      <= 1'b0;
      wd_count_reg   <= 8'd0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_op_valid && (is_load || is_store)) begin
            lsu_ready <= 1'b0;
            if (!legal) begin
              // Illegal funct3 outranks misalignment.
              state_reg <= ERR;
              lsu_err   <= 1'b1;
              err_cause <= 2'b10;
            end else if (misaligned) begin
              state_reg <= ERR;
              lsu_err   <= 1'b1;
              err_cause <= 2'b01;
            end else begin
              state_reg      <= BUSY;
              lsu_busy       <= 1'b1;
              mem.dmem_req   <= 1'b1;
              mem.dmem_we    <= is_store;
              mem.dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem.dmem_be    <= is_store ? st_be : 4'b1111;
              mem.dmem_wdata <= st_wdata;
              funct3_reg     <= funct3;
              rd_reg         <= rd_in;
              off_reg        <= addr[1:0];
              store_reg      <= is_store;
              wd_count_reg   <= 8'd0;
            end
          end
        end
        BUSY: begin
          if (mem.dmem_ack) begin
            // Ack wins even on the cycle the watchdog would expire.
            state_reg    <= IDLE;
            lsu_ready    <= 1'b1;
            lsu_busy     <= 1'b0;
            mem.dmem_req <= 1'b0;
            if (!store_reg) begin
              wb_valid <= (rd_reg != 5'd0);
              wb_rd    <= rd_reg;
              wb_data  <= ld_data;
            end
          end else if (wd_count_reg + 8'd1 == WD_LIMIT) begin
            state_reg    <= IDLE;
            lsu_ready    <= 1'b1;
            lsu_busy     <= 1'b0;
            mem.dmem_req <= 1'b0;
            lsu_err      <= 1'b1;
            err_cause    <= 2'b11;
          end else begin
            wd_count_reg <= wd_count_reg + 8'd1;
          end
        end
        default: begin
          // ERR lasts exactly one cycle; lsu_err was raised on entry.
          state_reg <= IDLE;
          lsu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the test plan
// followed by randomized operations checked against a behavioural model.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_op_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        lsu_ready, lsu_busy, wb_valid, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .mem_op_valid(mem_op_valid), .opcode(opcode),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
    .lsu_ready(lsu_ready), .lsu_busy(lsu_busy), .mem(mem_bus),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_err(lsu_err), .err_cause(err_cause)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] exp_cause(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (st) ok = (f3 < 3);
    else    ok = !(f3 == 3 || f3 == 6 || f3 == 7);
    if (!ok) return 2'd2;
    if ((a % size_bytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int v;
    if (!st) return 4'hF;
    v = ((1 << size_bytes(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (size_bytes(f3))
      1:       return (sd & 32'hFF) * 32'h01010101;
      2:       return (sd & 32'hFFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    longint v;
    int bits;
    bits = 8 * size_bytes(f3);
    v = longint'(rdata >> (8 * (a % 4)));
    if (bits < 32) begin
      v = v % (longint'(1) << bits);
      if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    end
    return v[31:0];
  endfunction

  // One load/store transaction. Called at a negedge with the unit idle.
  // d = cycles after the first req cycle at which ack is given (>= TMO: never).
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input int d,
                       input logic [31:0] rdata);
    logic [1:0] cause;
    int k;
    bit done;
    cause = exp_cause(st, f3, a);
    $display("op %s f3=%0d addr=%h sd=%h rd=%0d ackdly=%0d rdata=%h cause=%0d",
             st ? "ST" : "LD", f3, a, sd, rd, d, rdata, cause);
    check("ready_before", lsu_ready, 1'b1);
    mem_op_valid = 1'b1;
    opcode = st ? 7'b0100011 : 7'b0000011;
    funct3 = f3; addr = a; store_data = sd; rd_in = rd;
    @(negedge clk);
    mem_op_valid = 1'b0;
    check("wb_pulse_ended", wb_valid, 1'b0);
    check("ready_after_accept", lsu_ready, 1'b0);
    if (cause != 0) begin
      check("err_no_req", mem_bus.dmem_req, 1'b0);
      check("err_pulse", lsu_err, 1'b1);
      check("err_cause", err_cause, cause);
      @(negedge clk);
      check("err_one_cycle", lsu_err, 1'b0);
      check("err_ready_back", lsu_ready, 1'b1);
      check("err_cause_hold", err_cause, cause);
      return;
    end
    check("busy", lsu_busy, 1'b1);
    check("req", mem_bus.dmem_req, 1'b1);
    check("we", mem_bus.dmem_we, st);
    check("daddr", mem_bus.dmem_addr, {a[31:2], 2'b00});
    check("be", mem_bus.dmem_be, exp_be(st, f3, a));
    if (st) check("wdata", mem_bus.dmem_wdata, exp_wdata(f3, sd));
    k = 0;
    done = 0;
    while (!done) begin
      if (k == d) begin
        mem_bus.dmem_ack = 1'b1;
        mem_bus.dmem_rdata = rdata;
        @(negedge clk);
        mem_bus.dmem_ack = 1'b0;
        mem_bus.dmem_rdata = $urandom;
        check("done_req_low", mem_bus.dmem_req, 1'b0);
        check("done_ready", lsu_ready, 1'b1);
        check("done_no_err", lsu_err, 1'b0);
        check("wb_valid", wb_valid, (!st && rd != 0));
        if (!st && rd != 0) begin
          check("wb_rd", wb_rd, rd);
          check("wb_data", wb_data, exp_load(f3, a, rdata));
        end
        done = 1;
      end else if (k == TMO - 1) begin
        @(negedge clk);
        check("tmo_req_low", mem_bus.dmem_req, 1'b0);
        check("tmo_err", lsu_err, 1'b1);
        check("tmo_cause", err_cause, 2'd3);
        check("tmo_no_wb", wb_valid, 1'b0);
        check("tmo_ready", lsu_ready, 1'b1);
        done = 1;
      end else begin
        @(negedge clk);
        k++;
        check("req_held", mem_bus.dmem_req, 1'b1);
        check("addr_held", mem_bus.dmem_addr, {a[31:2], 2'b00});
      end
    end
  endtask

  // Non-memory opcode: must be ignored.
  task automatic do_other(input logic [6:0] opc);
    $display("op OTHER opcode=%b", opc);
    mem_op_valid = 1'b1;
    opcode = opc;
    funct3 = 3'($urandom);
    addr = $urandom;
    @(negedge clk);
    mem_op_valid = 1'b0;
    check("other_ready", lsu_ready, 1'b1);
    check("other_no_req", mem_bus.dmem_req, 1'b0);
    check("other_no_err", lsu_err, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    logic [4:0] rd;
    rst = 1'b1;
    mem_op_valid = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; rd_in = 5'd0;
    mem_bus.dmem_ack = 1'b0;
    mem_bus.dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", lsu_ready, 1'b1);
    check("rst_busy", lsu_busy, 1'b0);
    check("rst_req", mem_bus.dmem_req, 1'b0);
    check("rst_be", mem_bus.dmem_be, 4'd0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_err", lsu_err, 1'b0);
    check("rst_cause", err_cause, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the test plan.
    do_op(0, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF);
    do_op(0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 32'h80FFFF12);
    do_op(0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 32'h80FFFF12);
    do_op(1, 3'b001, 32'h22, 32'h1234ABCD, 5'd8, 1, 32'h0);
    do_op(0, 3'b010, 32'h101, 32'h0, 5'd9, 0, 32'h0);
    do_op(0, 3'b011, 32'h100, 32'h0, 5'd9, 0, 32'h0);
    do_op(0, 3'b010, 32'h200, 32'h0, 5'd10, TMO + 5, 32'h0);
    // Ack arriving after the timeout must be ignored.
    mem_bus.dmem_ack = 1'b1;
    mem_bus.dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_bus.dmem_ack = 1'b0;
    check("late_ack_no_wb", wb_valid, 1'b0);
    check("late_ack_no_err", lsu_err, 1'b0);
    check("late_ack_ready", lsu_ready, 1'b1);
    do_op(0, 3'b010, 32'h204, 32'h0, 5'd11, TMO - 1, 32'hCAFEF00D);
    do_op(0, 3'b010, 32'h208, 32'h0, 5'd0, 0, 32'h12345678);
    do_op(0, 3'b001, 32'h20A, 32'h0, 5'd12, 0, 32'h8001_7FFF);
    do_op(0, 3'b101, 32'h20A, 32'h0, 5'd13, 0, 32'h8001_7FFF);

    // Reset during BUSY discards the operation.
    $display("op LD then reset mid-busy");
    mem_op_valid = 1'b1; opcode = 7'b0000011; funct3 = 3'b010; addr = 32'h300; rd_in = 5'd3;
    @(negedge clk);
    mem_op_valid = 1'b0;
    check("pre_rst_req", mem_bus.dmem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req", mem_bus.dmem_req, 1'b0);
    check("midrst_ready", lsu_ready, 1'b1);
    check("midrst_no_wb", wb_valid, 1'b0);
    check("midrst_no_err", lsu_err, 1'b0);

    do_other(7'b0110011);

    // Randomized operations against the model.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        do_other(7'b0010011);
      end else begin
        f3 = 3'($urandom);
        if ($urandom_range(0, 3) != 0) f3[1:0] = 2'($urandom_range(0, 2));
        a = $urandom;
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        do_op(1'($urandom), f3, a, $urandom, rd, $urandom_range(0, TMO), $urandom);
      end
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the pipelined RV32I core. It sits between the register file's read/write ports and the data memory:
- Consumes the EX-stage address and the store operand read from the register file's second read port.
- Drives a single-outstanding req/ack data-memory interface.
- Returns sign- or zero-extended load data on the register file's write port.

Byte/halfword lane steering, alignment checking and a memory-timeout watchdog all live here.

## Interface
- DATA_WIDTH, 32, data path width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 16, maximum cycles in BUSY before abort; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_op_valid  in  1  EX/MEM register presents an operation this cycle.
- opcode  in  7  0000011 = load, 0100011 = store; any other value is ignored.
- funct3  in  3  access size and signedness.
- addr  in  ADDR_WIDTH  byte address (ALU result).
- store_data  in  DATA_WIDTH  store operand (register file rg_rd_data2).
- rd_in  in  5  load destination register.
- lsu_ready  out  1  high in IDLE; an operation is accepted when mem_op_valid & lsu_ready.
- lsu_busy  out  1  high in BUSY; the hazard unit stalls dependent stages.
- dmem_req  out  1  memory request, held until ack or timeout.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_ack  in  1  memory completes the request; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_WIDTH  read word.
- wb_valid  out  1  one-cycle write strobe (feeds rg_wrt_en).
- wb_rd  out  5  write destination (feeds rg_wrt_dest).
- wb_data  out  DATA_WIDTH  extended load result (feeds rg_wrt_data).
- lsu_err  out  1  one-cycle error pulse.
- err_cause  out  2  01 = misaligned, 10 = illegal funct3, 11 = timeout; holds its value until the next error.

## Operation
State machine:
- States are IDLE, BUSY and ERR.
- **IDLE → BUSY**: on accept of a legal, aligned operation. Latch addr, funct3, we, rd_in and store_data; compute be and wdata.
- **IDLE → ERR**: on accept of an illegal or misaligned operation. No memory request is issued.
- **BUSY → IDLE**: on dmem_ack, or when the watchdog count reaches TIMEOUT_CYCLES.
- **ERR → IDLE**: unconditionally after one cycle. lsu_err pulses while in ERR.

Legal funct3:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- All others are illegal (cause 10). Illegal funct3 takes priority over misalignment.

Misaligned (cause 01):
- Halfword access with addr[0] = 1.
- Word access with addr[1:0] ≠ 00.

Store lanes:
- SB: be = 0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
- SH: be = 0011 << (2·addr[1]); wdata = {2{store_data[15:0]}}.
- SW: be = 1111; wdata = store_data.

Loads:
- be = 1111.
- The byte or half is selected from dmem_rdata by the latched addr[1:0].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Writeback:
- Only loads produce writeback.
- wb_valid is suppressed when rd = 0, because the register file does not protect x0.
- Stores, errors and timeouts never assert wb_valid.

Watchdog:
- Clears on entry to BUSY and increments each BUSY cycle without ack.
- If ack arrives in the same cycle the count reaches the limit, ack wins: normal completion, no error.
- Ack outside BUSY is ignored.

## Timing
- Accept at rising edge N. dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and valid from cycle N+1.
- These outputs stay stable until ack.
- If ack is sampled at edge M, then at cycle M+1:
  - dmem_req = 0.
  - wb_valid/wb_rd/wb_data are registered and valid for that one cycle.
  - State is IDLE and lsu_ready = 1, so a new operation can be accepted at edge M+1.
- Minimum throughput is one operation per 2 cycles. Load-to-writeback latency is 2 cycles with zero-wait memory.
- Timeout: accept at edge N; dmem_req drops and lsu_err pulses in cycle N+TIMEOUT_CYCLES+1.
- Error on accept: lsu_err is high in cycle N+1 only, and lsu_ready returns at N+2.
- Reset values: all outputs 0 except lsu_ready = 1; err_cause = 00; state IDLE; counter 0.
- Reset asserted mid-BUSY: the pending operation is discarded with no writeback and no error. dmem_req is 0 in the cycle after the reset edge.

## Test plan
- **LW**: addr 0x100; ack 2 cycles after req with rdata 0xDEADBEEF → dmem_addr 0x100, be 1111; wb_valid one cycle, wb_data 0xDEADBEEF.
- **LB / LBU**: addr 0x103, rdata 0x80FF_FF12 → LB wb_data 0xFFFFFF80; LBU wb_data 0x00000080.
- **SH**: addr 0x22, store_data 0x1234ABCD → dmem_addr 0x20, be 1100, wdata 0xABCDABCD, we 1; no wb_valid.
- **Misaligned LW**: addr 0x101 → no dmem_req; lsu_err one cycle with err_cause 01. funct3 011 → err_cause 10.
- **Timeout**: TIMEOUT_CYCLES = 4, ack never arrives → req held 4 cycles then drops; err_cause 11; later ack ignored. Ack on the 4th cycle → normal completion, no error.
- **Boundaries**:
  - Load to rd = 0 → no wb_valid.
  - rst asserted during BUSY → next cycle dmem_req 0 and lsu_ready 1.
  - Back-to-back loads → second accepted at cycle M+1.
